// File: rtl/clk_rst_seq_if.sv
// clk_rst_seq_if
//   Groups the sequencer's status and control signals into one bundle.
//   master : the sequencer (samples mmcm_locked/retry_req, drives the rest)
//   slave  : the surrounding logic / MMCM side
// Signals:
//   mmcm_locked   MMCM locked status (asynchronous to sys_clk)
//   retry_req     single-cycle pulse that leaves FAULT
//   mmcm_rst      MMCM reset, active-high
//   domain_rst    per-domain resets, active-high, bit 0 released first
//   ready         all domains released and MMCM locked
//   fail          sticky fault flag
//   lock_loss_cnt saturating count of lock losses seen while running
//   state         HOLD=0, WAIT_LOCK=1, STAGGER=2, RUN=3, FAULT=4
interface clk_rst_seq_if #(
  parameter int NUM_DOMAINS = 3,
  parameter int CNT_W       = 8
);
  logic                   mmcm_locked;
  logic                   retry_req;
  logic                   mmcm_rst;
  logic [NUM_DOMAINS-1:0] domain_rst;
  logic                   ready;
  logic                   fail;
  logic [CNT_W-1:0]       lock_loss_cnt;
  logic [2:0]             state;

  modport master (
    input  mmcm_locked, retry_req,
    output mmcm_rst, domain_rst, ready, fail, lock_loss_cnt, state
  );

  modport slave (
    output mmcm_locked, retry_req,
    input  mmcm_rst, domain_rst, ready, fail, lock_loss_cnt, state
  );
endinterface

// File: rtl/clk_rst_seq.sv
// clk_rst_seq
//   Clock/reset sequencer in the sys_clk domain. Holds the MMCM in reset,
//   qualifies its locked status, then releases the downstream domain resets
//   one at a time in index order. Lock loss re-sequences from HOLD, lock
//   timeouts retry, and repeated timeouts park the block in a sticky FAULT.
// Ports:
//   sys_clk    block clock
//   sys_rst_n  asynchronous active-low reset
//   bus        clk_rst_seq_if.master (see interface file for signal list)
module clk_rst_seq #(
  parameter int SYNC_STAGES     = 2,
  parameter int RST_HOLD_CYCLES = 16,
  parameter int LOCK_STABLE     = 4,
  parameter int LOCK_TIMEOUT    = 1024,
  parameter int MAX_RETRIES     = 3,
  parameter int NUM_DOMAINS     = 3,
  parameter int STAGGER_CYCLES  = 8,
  parameter int CNT_W           = 8
) (
  input  logic          sys_clk,
  input  logic          sys_rst_n,
  clk_rst_seq_if.master bus
);

  localparam int HOLD_W = $clog2(RST_HOLD_CYCLES + 1);
  localparam int STAB_W = $clog2(LOCK_STABLE + 1);
  localparam int TO_W   = $clog2(LOCK_TIMEOUT + 1);
  localparam int RTR_W  = $clog2(MAX_RETRIES + 1);
  localparam int SUB_W  = $clog2(STAGGER_CYCLES + 1);

  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(RST_HOLD_CYCLES);
  localparam logic [STAB_W-1:0] STAB_LAST = STAB_W'(LOCK_STABLE - 1);
  localparam logic [TO_W-1:0]   TO_LAST   = TO_W'(LOCK_TIMEOUT - 1);
  localparam logic [RTR_W-1:0]  RTR_MAX   = RTR_W'(MAX_RETRIES);
  localparam logic [SUB_W-1:0]  SUB_LAST  = SUB_W'(STAGGER_CYCLES - 1);

  typedef enum logic [2:0] {
    HOLD      = 3'd0,
    WAIT_LOCK = 3'd1,
    STAGGER   = 3'd2,
    RUN       = 3'd3,
    FAULT     = 3'd4
  } state_t;

  state_t                 state_reg;
  logic [SYNC_STAGES-1:0] sync_reg;
  logic [HOLD_W-1:0]      hold_cnt_reg;
  logic [STAB_W-1:0]      stable_cnt_reg;
  logic [TO_W-1:0]        timeout_cnt_reg;
  logic [RTR_W-1:0]       retry_cnt_reg;
  logic [SUB_W-1:0]       sub_cnt_reg;
  logic                   mmcm_rst_reg;
  logic [NUM_DOMAINS-1:0] domain_rst_reg;
  logic                   ready_reg;
  logic                   fail_reg;
  logic [CNT_W-1:0]       lock_loss_cnt_reg;

  logic                   locked_s;
  logic                   lock_qualified;
  logic [RTR_W-1:0]       retry_inc;
  logic [NUM_DOMAINS-1:0] domain_shift;

  assign locked_s       = sync_reg[SYNC_STAGES-1];
  assign lock_qualified = locked_s && (stable_cnt_reg == STAB_LAST);
  assign retry_inc      = retry_cnt_reg + RTR_W'(1);
  // Shifting zeros in from bit 0 makes out-of-order release impossible.
  assign domain_shift   = domain_rst_reg << 1;

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_reg         <= HOLD;
      sync_reg          <= '0;
      hold_cnt_reg      <= '0;
      stable_cnt_reg    <= '0;
      timeout_cnt_reg   <= '0;
      retry_cnt_reg     <= '0;
      sub_cnt_reg       <= '0;
      mmcm_rst_reg      <= 1'b1;
      domain_rst_reg    <= '1;
      ready_reg         <= 1'b0;
      fail_reg          <= 1'b0;
      lock_loss_cnt_reg <= '0;
    end else begin
      sync_reg <= {sync_reg[SYNC_STAGES-2:0], bus.mmcm_locked};

      case (state_reg)
        HOLD: begin
          mmcm_rst_reg   <= 1'b1;
          domain_rst_reg <= '1;
          ready_reg      <= 1'b0;
          if (hold_cnt_reg == HOLD_LAST) begin
            state_reg       <= WAIT_LOCK;
            mmcm_rst_reg    <= 1'b0;
            stable_cnt_reg  <= '0;
            timeout_cnt_reg <= '0;
          end else begin
            hold_cnt_reg <= hold_cnt_reg + HOLD_W'(1);
          end
        end

        WAIT_LOCK: begin
          if (lock_qualified) begin
            state_reg     <= STAGGER;
            retry_cnt_reg <= '0;
            sub_cnt_reg   <= '0;
          end else begin
            stable_cnt_reg <= locked_s ? stable_cnt_reg + STAB_W'(1) : '0;
            // Timeout only matters while the lock is not yet qualified.
            if (timeout_cnt_reg == TO_LAST) begin
              retry_cnt_reg <= retry_inc;
              mmcm_rst_reg  <= 1'b1;
              // The transition edge itself counts as the first hold cycle.
              hold_cnt_reg  <= HOLD_W'(1);
              if (retry_inc == RTR_MAX) begin
                state_reg <= FAULT;
                fail_reg  <= 1'b1;
              end else begin
                state_reg <= HOLD;
              end
            end else begin
              timeout_cnt_reg <= timeout_cnt_reg + TO_W'(1);
            end
          end
        end

        STAGGER: begin
          // Lock loss wins over a release due on the same edge.
          if (!locked_s) begin
            state_reg      <= HOLD;
            mmcm_rst_reg   <= 1'b1;
            domain_rst_reg <= '1;
            ready_reg      <= 1'b0;
            hold_cnt_reg   <= HOLD_W'(1);
          end else if (sub_cnt_reg == SUB_LAST) begin
            sub_cnt_reg    <= '0;
            domain_rst_reg <= domain_shift;
            if (domain_shift == '0) begin
              state_reg <= RUN;
              ready_reg <= 1'b1;
            end
          end else begin
            sub_cnt_reg <= sub_cnt_reg + SUB_W'(1);
          end
        end

        RUN: begin
          if (!locked_s) begin
            state_reg      <= HOLD;
            mmcm_rst_reg   <= 1'b1;
            domain_rst_reg <= '1;
            ready_reg      <= 1'b0;
            hold_cnt_reg   <= HOLD_W'(1);
            if (lock_loss_cnt_reg != '1)
              lock_loss_cnt_reg <= lock_loss_cnt_reg + CNT_W'(1);
          end
        end

        FAULT: begin
          mmcm_rst_reg   <= 1'b1;
          domain_rst_reg <= '1;
          ready_reg      <= 1'b0;
          fail_reg       <= 1'b1;
          if (bus.retry_req) begin
            state_reg     <= HOLD;
            fail_reg      <= 1'b0;
            retry_cnt_reg <= '0;
            hold_cnt_reg  <= HOLD_W'(1);
          end
        end

        default: begin
          state_reg      <= HOLD;
          mmcm_rst_reg   <= 1'b1;
          domain_rst_reg <= '1;
          ready_reg      <= 1'b0;
          hold_cnt_reg   <= '0;
        end
      endcase
    end
  end

  assign bus.state         = state_reg;
  assign bus.mmcm_rst      = mmcm_rst_reg;
  assign bus.domain_rst    = domain_rst_reg;
  assign bus.ready         = ready_reg;
  assign bus.fail          = fail_reg;
  assign bus.lock_loss_cnt = lock_loss_cnt_reg;

endmodule

// File: tb/tb_clk_rst_seq.sv
// tb_clk_rst_seq
//   Scoreboard bench for clk_rst_seq. The stimulus process pushes each
//   expected output change (edge number + output tuple) into a queue; the
//   monitor pops and compares whenever the DUT outputs change.
module tb_clk_rst_seq;
  localparam int ND = 3;
  localparam int CW = 2;

  logic sys_clk   = 1'b0;
  logic sys_rst_n = 1'b1;

  clk_rst_seq_if #(.NUM_DOMAINS(ND), .CNT_W(CW)) bus ();

  clk_rst_seq #(
    .SYNC_STAGES(2), .RST_HOLD_CYCLES(16), .LOCK_STABLE(4),
    .LOCK_TIMEOUT(1024), .MAX_RETRIES(3), .NUM_DOMAINS(ND),
    .STAGGER_CYCLES(8), .CNT_W(CW)
  ) dut (
    .sys_clk  (sys_clk),
    .sys_rst_n(sys_rst_n),
    .bus      (bus.master)
  );

  always #5 sys_clk = ~sys_clk;

  // Edge 0 is the first rising edge after reset release.
  int edge_num = -1;
  always @(posedge sys_clk) begin
    if (!sys_rst_n) edge_num = -1;
    else            edge_num = edge_num + 1;
  end

  typedef struct {
    int          edge_n;
    logic [10:0] obs;
  } exp_t;

  exp_t exp_q[$];
  int   compared   = 0;
  int   mismatched = 0;

  function automatic string fmt(input logic [10:0] o);
    return $sformatf("st=%0d mmcm_rst=%b dom=%b rdy=%b fail=%b cnt=%0d",
                     o[10:8], o[7], o[6:4], o[3], o[2], o[1:0]);
  endfunction

  task automatic push(input int e, input int st, input bit mr, input int dr,
                      input bit rdy, input bit fl, input int cnt);
    exp_t x;
    x.edge_n = e;
    x.obs    = {st[2:0], mr, dr[2:0], rdy, fl, cnt[1:0]};
    exp_q.push_back(x);
  endtask

  task automatic wait_edge(input int n);
    int guard;
    guard = 0;
    @(negedge sys_clk);
    while (edge_num < n && guard < 5000) begin
      @(negedge sys_clk);
      guard++;
    end
  endtask

  // Monitor: one transaction per observed output change.
  logic [10:0] prev_obs;
  bit          first_obs = 1'b1;
  always @(negedge sys_clk) begin
    logic [10:0] cur;
    exp_t        e;
    cur = {bus.state, bus.mmcm_rst, bus.domain_rst, bus.ready, bus.fail,
           bus.lock_loss_cnt};
    if (first_obs || cur !== prev_obs) begin
      first_obs = 1'b0;
      prev_obs  = cur;
      compared++;
      if (exp_q.size() == 0) begin
        mismatched++;
        $display("FAIL unexpected_change got edge=%0d %s required no change",
                 edge_num, fmt(cur));
      end else begin
        e = exp_q.pop_front();
        if (e.obs !== cur || e.edge_n != edge_num) begin
          mismatched++;
          $display("FAIL seq_event got edge=%0d %s required edge=%0d %s",
                   edge_num, fmt(cur), e.edge_n, fmt(e.obs));
        end else begin
          $display("chk edge=%0d %s ok", edge_num, fmt(cur));
        end
      end
    end
  end

  initial begin
    #100000;
    mismatched++;
    $display("FAIL watchdog got time=%0t required finish before 100000", $time);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  initial begin
    bus.mmcm_locked = 1'b0;
    bus.retry_req   = 1'b0;
    push(-1, 0, 1, 3'b111, 0, 0, 0);
    #1 sys_rst_n = 1'b0;
    repeat (3) @(negedge sys_clk);
    sys_rst_n = 1'b1;

    // Clean lock
    push(16, 1, 0, 3'b111, 0, 0, 0);
    push(46, 2, 0, 3'b111, 0, 0, 0);
    push(54, 2, 0, 3'b110, 0, 0, 0);
    push(62, 2, 0, 3'b100, 0, 0, 0);
    push(70, 3, 0, 3'b000, 1, 0, 0);
    wait_edge(40);  bus.mmcm_locked = 1'b1;

    // Loss in RUN, then glitchy relock, then loss in STAGGER on a release edge
    push(83,  0, 1, 3'b111, 0, 0, 1);
    push(99,  1, 0, 3'b111, 0, 0, 1);
    push(111, 2, 0, 3'b111, 0, 0, 1);
    push(119, 2, 0, 3'b110, 0, 0, 1);
    push(127, 0, 1, 3'b111, 0, 0, 1);
    push(143, 1, 0, 3'b111, 0, 0, 1);
    push(156, 2, 0, 3'b111, 0, 0, 1);
    push(164, 2, 0, 3'b110, 0, 0, 1);
    push(172, 2, 0, 3'b100, 0, 0, 1);
    push(180, 3, 0, 3'b000, 1, 0, 1);
    wait_edge(80);  bus.mmcm_locked = 1'b0;
    wait_edge(100); bus.mmcm_locked = 1'b1;
    wait_edge(103); bus.mmcm_locked = 1'b0;
    wait_edge(105); bus.mmcm_locked = 1'b1;
    wait_edge(124); bus.mmcm_locked = 1'b0;
    wait_edge(150); bus.mmcm_locked = 1'b1;

    // Timeouts into FAULT, retry, relock
    push(193,  0, 1, 3'b111, 0, 0, 2);
    push(209,  1, 0, 3'b111, 0, 0, 2);
    push(1233, 0, 1, 3'b111, 0, 0, 2);
    push(1249, 1, 0, 3'b111, 0, 0, 2);
    push(2273, 0, 1, 3'b111, 0, 0, 2);
    push(2289, 1, 0, 3'b111, 0, 0, 2);
    push(3313, 4, 1, 3'b111, 0, 1, 2);
    push(3321, 0, 1, 3'b111, 0, 0, 2);
    push(3337, 1, 0, 3'b111, 0, 0, 2);
    push(3341, 2, 0, 3'b111, 0, 0, 2);
    push(3349, 2, 0, 3'b110, 0, 0, 2);
    push(3357, 2, 0, 3'b100, 0, 0, 2);
    push(3365, 3, 0, 3'b000, 1, 0, 2);
    wait_edge(190);  bus.mmcm_locked = 1'b0;
    wait_edge(500);  bus.retry_req = 1'b1;   // ignored outside FAULT
    wait_edge(501);  bus.retry_req = 1'b0;
    wait_edge(3320); bus.retry_req = 1'b1; bus.mmcm_locked = 1'b1;
    wait_edge(3321); bus.retry_req = 1'b0;
    wait_edge(3370); bus.retry_req = 1'b1;   // ignored in RUN
    wait_edge(3371); bus.retry_req = 1'b0;

    // Counter saturation at 3 over further RUN losses
    push(3383, 0, 1, 3'b111, 0, 0, 3);
    push(3399, 1, 0, 3'b111, 0, 0, 3);
    push(3406, 2, 0, 3'b111, 0, 0, 3);
    push(3414, 2, 0, 3'b110, 0, 0, 3);
    push(3422, 2, 0, 3'b100, 0, 0, 3);
    push(3430, 3, 0, 3'b000, 1, 0, 3);
    push(3443, 0, 1, 3'b111, 0, 0, 3);
    push(3459, 1, 0, 3'b111, 0, 0, 3);
    push(3466, 2, 0, 3'b111, 0, 0, 3);
    push(3474, 2, 0, 3'b110, 0, 0, 3);
    push(3482, 2, 0, 3'b100, 0, 0, 3);
    push(3490, 3, 0, 3'b000, 1, 0, 3);
    push(3503, 0, 1, 3'b111, 0, 0, 3);
    push(3519, 1, 0, 3'b111, 0, 0, 3);
    push(3526, 2, 0, 3'b111, 0, 0, 3);
    push(3534, 2, 0, 3'b110, 0, 0, 3);
    wait_edge(3380); bus.mmcm_locked = 1'b0;
    wait_edge(3400); bus.mmcm_locked = 1'b1;
    wait_edge(3440); bus.mmcm_locked = 1'b0;
    wait_edge(3460); bus.mmcm_locked = 1'b1;
    wait_edge(3500); bus.mmcm_locked = 1'b0;
    wait_edge(3520); bus.mmcm_locked = 1'b1;

    // Asynchronous reset mid-STAGGER, between clock edges
    push(3537, 0, 1, 3'b111, 0, 0, 0);
    wait_edge(3536);
    @(posedge sys_clk);
    #1 sys_rst_n = 1'b0;
    repeat (3) @(negedge sys_clk);

    // Restart with lock already present
    push(16, 1, 0, 3'b111, 0, 0, 0);
    push(20, 2, 0, 3'b111, 0, 0, 0);
    push(28, 2, 0, 3'b110, 0, 0, 0);
    push(36, 2, 0, 3'b100, 0, 0, 0);
    push(44, 3, 0, 3'b000, 1, 0, 0);
    sys_rst_n = 1'b1;
    wait_edge(60);

    compared++;
    if (exp_q.size() != 0) begin
      mismatched++;
      $display("FAIL leftover_expect got pending=%0d required 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
